// File: rtl/logic_gate_tester.sv
// Stimulus/response engine for a two-input gate block: walks {b,a} through 00,01,10,11,
// samples the six gate outputs after a settle delay and accumulates mismatch results.
module logic_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [5:0]       gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [5:0]       first_fail_mask
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StReport} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       settle_cnt_q;
  logic [1:0]       vec_idx_q;
  logic             fail_seen_q;

  logic [5:0]       expected;
  logic [5:0]       mismatch;
  logic [2:0]       mis_cnt;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;
  logic [1:0]       vec_idx_nxt;

  always_comb begin
    expected = {~a_out, a_out ^ b_out, ~(a_out | b_out), ~(a_out & b_out),
                a_out | b_out, a_out & b_out};
    mismatch = expected ^ gate_in;
    mis_cnt  = '0;
    for (int i = 0; i < 6; i++) begin
      mis_cnt = mis_cnt + {2'b00, mismatch[i]};
    end
    // One extra bit catches the carry so the total can saturate instead of wrapping.
    err_sum     = {1'b0, err_count} + {{(ERR_W - 2){1'b0}}, mis_cnt};
    err_next    = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    vec_idx_nxt = vec_idx_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      settle_cnt_q    <= '0;
      vec_idx_q       <= '0;
      fail_seen_q     <= 1'b0;
      a_out           <= 1'b0;
      b_out           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            err_count       <= '0;
            pass            <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
            fail_seen_q     <= 1'b0;
            vec_idx_q       <= '0;
            a_out           <= 1'b0;
            b_out           <= 1'b0;
            busy            <= 1'b1;
            settle_cnt_q    <= '0;
            state_q         <= StSettle;
          end
        end
        StSettle: begin
          settle_cnt_q <= settle_cnt_q + 4'd1;
          if (settle_cnt_q == SettleLast) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          err_count <= err_next;
          if ((mismatch != 6'd0) && !fail_seen_q) begin
            first_fail_vec  <= {b_out, a_out};
            first_fail_mask <= mismatch;
            fail_seen_q     <= 1'b1;
          end
          if (vec_idx_q == 2'd3) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (err_next == '0);
            state_q <= StReport;
          end else begin
            vec_idx_q    <= vec_idx_nxt;
            a_out        <= vec_idx_nxt[0];
            b_out        <= vec_idx_nxt[1];
            settle_cnt_q <= '0;
            state_q      <= StSettle;
          end
        end
        StReport: begin
          done    <= 1'b0;
          a_out   <= 1'b0;
          b_out   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
